// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and
// default geometry/timing parameters.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    ERROR   = 3'd4
  } state_e;

  localparam int          DEF_DEPTH         = 1024;
  localparam logic [31:0] DEF_BASE_ADDR     = 32'h0000_0000;
  localparam int          DEF_RELEASE_DELAY = 4;

endpackage

// File: rtl/imem_loader_release_counter.sv
// Loadable down-counter that times how long the core stays in reset after
// the last instruction word is written.
module release_counter #(
  parameter int W = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge Clk) begin
    if (!Reset)                      count <= '0;
    else if (load)                   count <= load_value;
    else if (dec && (count != '0))   count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/imem_loader.sv
// Streams a program into instruction memory, then releases the core from
// reset after a fixed delay; flags overflow when the program exceeds DEPTH.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH         = DEF_DEPTH,
  parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
  parameter int          RELEASE_DELAY = DEF_RELEASE_DELAY
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic                     InValid,
  input  logic [31:0]              InData,
  input  logic                     InLast,
  output logic                     InReady,
  output logic                     ImemWriteEn,
  output logic [31:0]              ImemAddr,
  output logic [31:0]              ImemWriteData,
  output logic                     CoreReset,
  output logic                     Done,
  output logic                     Error,
  output logic [$clog2(DEPTH):0]   WordCount
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

  state_e      state;
  logic        accept;
  logic        rel_zero;
  logic [31:0] word_addr;

  assign InReady   = (state == LOAD);
  assign accept    = InValid && InReady;
  assign word_addr = BASE_ADDR + (32'(WordCount) << 2);

  // Loaded with DELAY-1 so the RELEASE state lasts exactly RELEASE_DELAY cycles.
  release_counter #(.W(RW)) u_rel (
    .Clk        (Clk),
    .Reset      (Reset),
    .load       (accept && InLast),
    .load_value (RW'(RELEASE_DELAY - 1)),
    .dec        (state == RELEASE),
    .zero       (rel_zero)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state         <= IDLE;
      CoreReset     <= 1'b1;
      ImemWriteEn   <= 1'b0;
      ImemAddr      <= BASE_ADDR;
      ImemWriteData <= '0;
      Done          <= 1'b0;
      Error         <= 1'b0;
      WordCount     <= '0;
    end else begin
      ImemWriteEn <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          state     <= LOAD;
          WordCount <= '0;
        end
        LOAD: if (accept) begin
          ImemWriteEn   <= 1'b1;
          ImemAddr      <= word_addr;
          ImemWriteData <= InData;
          WordCount     <= WordCount + CW'(1);
          if (InLast) state <= RELEASE;
          else if (WordCount == CW'(DEPTH - 1)) begin
            // The overflowing word is still written; only further words are refused.
            state <= ERROR;
            Error <= 1'b1;
          end
        end
        RELEASE: if (rel_zero) begin
          state     <= RUN;
          CoreReset <= 1'b0;
          Done      <= 1'b1;
        end
        RUN: if (Start) begin
          state     <= LOAD;
          CoreReset <= 1'b1;
          Done      <= 1'b0;
          WordCount <= '0;
        end
        ERROR: if (Start) begin
          state     <= LOAD;
          Error     <= 1'b0;
          WordCount <= '0;
        end
        default: begin
          state     <= IDLE;
          CoreReset <= 1'b1;
          Done      <= 1'b0;
          Error     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed scenarios plus random traffic
// checked against a session-level reference model.
module tb_imem_loader;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          RD    = 4;

  logic        Clk = 1'b0;
  logic        Reset, Start, InValid, InLast;
  logic [31:0] InData;
  logic        InReady, ImemWriteEn, CoreReset, Done, Error;
  logic [31:0] ImemAddr, ImemWriteData;
  logic [$clog2(DEPTH):0] WordCount;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RELEASE_DELAY(RD)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InValid(InValid), .InData(InData),
    .InLast(InLast), .InReady(InReady), .ImemWriteEn(ImemWriteEn), .ImemAddr(ImemAddr),
    .ImemWriteData(ImemWriteData), .CoreReset(CoreReset), .Done(Done), .Error(Error),
    .WordCount(WordCount)
  );

  always #5 Clk = ~Clk;

  typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t q[$];

  // Reference model: session phase, words written, release cycles left.
  typedef enum int { M_IDLE, M_LOAD, M_REL, M_RUN, M_ERR } mode_e;
  mode_e m_mode = M_IDLE;
  int    m_cnt = 0, m_rel = 0, cyc_n = 0;
  int    checks = 0, errors = 0, writes = 0;
  bit    armed = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_n, act, exp);
    end
  endtask

  // One clock: present inputs, advance the model at the edge, release inputs.
  task automatic step(bit rst_n, bit st, bit v, logic [31:0] d, bit l);
    Reset = rst_n; Start = st; InValid = v; InData = d; InLast = l;
    @(posedge Clk);
    cyc_n++;
    if (!rst_n) begin
      m_mode = M_IDLE; m_cnt = 0; armed = 1;
    end else begin
      case (m_mode)
        M_IDLE: if (st) begin m_mode = M_LOAD; m_cnt = 0; end
        M_LOAD: if (v) begin
          q.push_back('{cyc_n, BASE + 32'(4 * m_cnt), d});
          m_cnt++;
          if (l) begin m_mode = M_REL; m_rel = RD; end
          else if (m_cnt == DEPTH) m_mode = M_ERR;
        end
        M_REL: begin m_rel--; if (m_rel == 0) m_mode = M_RUN; end
        M_RUN, M_ERR: if (st) begin m_mode = M_LOAD; m_cnt = 0; end
        default: ;
      endcase
    end
    #1;
    Start = 0; InValid = 0; InLast = 0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 32'h0, 0);
  endtask

  // Monitor: compares every observable output against the model mid-cycle.
  initial begin
    wr_t e;
    bit  exp_we;
    forever begin
      @(negedge Clk);
      if (armed) begin
        exp_we = (q.size() > 0) && (q[0].cyc == cyc_n);
        chk("write_en", 32'(ImemWriteEn), 32'(exp_we));
        if (exp_we) begin
          e = q.pop_front();
          writes++;
          if (ImemWriteEn) begin
            chk("addr", ImemAddr, e.addr);
            chk("data", ImemWriteData, e.data);
          end
        end
        chk("in_ready",   32'(InReady),   32'(m_mode == M_LOAD));
        chk("core_reset", 32'(CoreReset), 32'(m_mode != M_RUN));
        chk("done",       32'(Done),      32'(m_mode == M_RUN));
        chk("error",      32'(Error),     32'(m_mode == M_ERR));
        chk("word_count", 32'(WordCount), 32'(m_cnt));
      end
    end
  end

  initial begin
    int w0;
    Reset = 0; Start = 0; InValid = 0; InData = 0; InLast = 0;
    @(negedge Clk);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 32'hDEAD_BEEF, 0);   // reset dominates Start/InValid
    chk("reset_addr", ImemAddr, BASE);
    chk("reset_wdata", ImemWriteData, 32'h0);

    // Three-word program, continuous valid, then release and run.
    w0 = writes;
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 32'h2002_0005, 0);
    step(1, 0, 1, 32'h2003_0007, 0);
    step(1, 0, 1, 32'h0000_0000, 1);
    idle(RD + 3);
    chk("prog3_writes", 32'(writes - w0), 32'd3);
    chk("prog3_done", 32'(Done), 32'd1);

    // Restart from RUN with a single word.
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 32'hFFFF_FFFF, 1);
    idle(RD + 3);

    // Gapped valid: two words, no counted gaps.
    w0 = writes;
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 32'h1111_0001, 0);
    step(1, 0, 0, 32'h5555_5555, 0);
    step(1, 0, 1, 32'h1111_0002, 1);
    step(1, 0, 0, 32'h5555_5555, 0);
    idle(RD + 2);
    chk("gap_writes", 32'(writes - w0), 32'd2);

    // Start ignored inside LOAD and RELEASE.
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 32'hA000_0001, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 32'hA000_0002, 1);
    step(1, 1, 0, 0, 0);
    idle(RD + 2);

    // Overflow: five words without InLast; fifth refused; then recover.
    w0 = writes;
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 32'hB000_0000 + 32'(i), 0);
    idle(3);
    chk("ovf_writes", 32'(writes - w0), 32'(DEPTH));
    chk("ovf_error", 32'(Error), 32'd1);
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 32'hC0DE_0001, 1);
    idle(RD + 2);

    // Reset mid-load after two accepts, with a third word pending.
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 32'hD000_0001, 0);
    step(1, 0, 1, 32'hD000_0002, 0);
    step(0, 1, 1, 32'hD000_0003, 0);
    chk("rst_mid_we", 32'(ImemWriteEn), 32'd0);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 60) != 0), ($urandom_range(0, 9) == 0),
           $urandom_range(0, 1), $urandom, ($urandom_range(0, 3) == 0));
    idle(RD + 3);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 1024, instruction-memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 0, byte address of the first loaded word.
REQ-003 Parameter RELEASE_DELAY, default 4, cycles between the last write and core reset release.
REQ-004 Clk  in  1  clock; all state updates on rising edge.
REQ-005 Reset  in  1  synchronous, active-low.
REQ-006 Start  in  1  single-cycle request to begin a load session.
REQ-007 InValid  in  1  InData/InLast valid.
REQ-008 InData  in  32  instruction word.
REQ-009 InLast  in  1  marks final word of program.
REQ-010 InReady  out  1  loader accepts a word this cycle.
REQ-011 ImemWriteEn  out  1  instruction-memory write strobe.
REQ-012 ImemAddr  out  32  byte address, word-aligned.
REQ-013 ImemWriteData  out  32  word to write.
REQ-014 CoreReset  out  1  active-high reset to datapath; 1 = core held.
REQ-015 Done  out  1  program loaded, core running.
REQ-016 Error  out  1  overflow; program exceeded DEPTH.
REQ-017 WordCount  out  clog2(DEPTH)+1  words written this session.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, RELEASE, RUN, ERROR.
REQ-019 IDLE: Start=1 -> LOAD; WordCount cleared to 0 on that edge.
REQ-020 InReady SHALL be 1 only in LOAD; combinational from state.
REQ-021 Accept = InValid & InReady; no word SHALL be accepted outside LOAD.
REQ-022 Accepted word SHALL produce ImemWriteEn=1 for exactly one cycle, the cycle after accept (latency 1).
REQ-023 ImemAddr SHALL equal BASE_ADDR + 4*WordCount-before-increment; ImemWriteData = accepted InData.
REQ-024 WordCount SHALL increment by 1 per accept; back-to-back accepts every cycle SHALL be supported.
REQ-025 Accept with InLast=1 -> RELEASE.
REQ-026 Accept of word index DEPTH-1 with InLast=0 -> ERROR; that word is still written.
REQ-027 RELEASE: CoreReset held 1 for RELEASE_DELAY cycles, then -> RUN.
REQ-028 RUN: CoreReset=0, Done=1.
REQ-029 RUN with Start=1 -> LOAD; CoreReset=1 and Done=0 from next cycle; WordCount cleared.
REQ-030 ERROR: Error=1, CoreReset=1; only Start=1 exits, to LOAD with WordCount cleared and Error cleared.
REQ-031 Start in LOAD or RELEASE SHALL be ignored.
REQ-032 CoreReset SHALL be 1 in every state except RUN.

Reset
REQ-033 Reset=0 at a rising edge: state IDLE, CoreReset=1, InReady=0, ImemWriteEn=0, ImemAddr=BASE_ADDR, ImemWriteData=0, Done=0, Error=0, WordCount=0, release counter 0.
REQ-034 Reset asserted mid-LOAD SHALL suppress any pending write; no ImemWriteEn after reset edge.
REQ-035 Reset SHALL dominate Start and InValid in the same cycle.

Structure
REQ-036 Shared package imem_loader_pkg SHALL hold the state enumeration and DEPTH/BASE_ADDR/RELEASE_DELAY defaults.
REQ-037 One sub-module release_counter (load, count down, zero flag) SHALL implement the RELEASE delay.
REQ-038 Implementation SHALL be single clock domain, no latches, all outputs registered except InReady.

Verification
REQ-039 Reset, Start, 3 words 0x20020005, 0x20030007, 0x00000000 (last), InValid continuous -> writes at addr 0, 4, 8 on consecutive cycles, WordCount=3, CoreReset falls 4 cycles after third write, Done=1.
REQ-040 InValid toggled 1,0,1,0 with 2 words -> exactly 2 writes, addresses 0 and 4, no gaps counted.
REQ-041 DEPTH=4, 5 words no InLast -> 4 writes (0..12), Error=1, InReady=0, 5th word not accepted, CoreReset=1.
REQ-042 Reset=0 during LOAD after 2 accepts -> next cycle ImemWriteEn=0, state IDLE, WordCount=0, CoreReset=1.
REQ-043 In RUN, Start=1 then 1 word 0xFFFFFFFF (last) -> CoreReset=1, Done=0, write at addr 0, Done=1 again after RELEASE_DELAY.
REQ-044 Start pulsed during LOAD and RELEASE -> no state change, WordCount unaffected.
